// File: rtl/inst_fetch_if.sv
// Purpose : Bundle of the fetch-stage control, ROM and decode-handshake signals.
// Modports:
//   master - the fetch stage (drives rom_addr, instr*, halted, fetch_count)
//   slave  - the surrounding CPU/ROM (drives start, rom_data, redirect*, instr_ready)
// Signals :
//   start          1       one-cycle pulse that begins fetching
//   rom_addr       ADDR_W  ROM address (equals the PC)
//   rom_data       DATA_W  combinational ROM read data
//   redirect_valid 1       taken jump/branch from execute
//   redirect_pc    ADDR_W  redirect target
//   instr_valid    1       instr/instr_pc hold a word for decode
//   instr_ready    1       decode accepts the word this cycle
//   instr          DATA_W  registered instruction word
//   instr_pc       ADDR_W  address the word was fetched from
//   halted         1       high once the halt word has been accepted
//   fetch_count    16      accepted-instruction counter
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              halted;
  logic [15:0]       fetch_count;

  modport master (
    input  start, rom_data, redirect_valid, redirect_pc, instr_ready,
    output rom_addr, instr_valid, instr, instr_pc, halted, fetch_count
  );

  modport slave (
    output start, rom_data, redirect_valid, redirect_pc, instr_ready,
    input  rom_addr, instr_valid, instr, instr_pc, halted, fetch_count
  );
endinterface

// File: rtl/inst_fetch.sv
// Purpose : Instruction fetch stage for the 10-bit teaching CPU. Drives the
//           ROM address from the PC, registers each returned word into an
//           instruction register and offers it to decode via valid/ready.
//           Handles redirects, decode stalls and the halt word.
// Ports   :
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - inst_fetch_if.master (start, ROM, redirect, decode handshake,
//            halted, fetch_count)
// Options : define FETCH_PERF_EN to build the saturating accepted-word
//           counter on fetch_count; otherwise fetch_count is tied to 0.
module inst_fetch #(
  parameter int unsigned       ADDR_W    = 10,
  parameter int unsigned       DATA_W    = 10,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(10'b0010000010)
) (
  input  logic         clk,
  input  logic         rst_n,
  inst_fetch_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DRAIN  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [DATA_W-1:0] r_instr;
  logic [DATA_W-1:0] w_instr_nxt;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [ADDR_W-1:0] w_instr_pc_nxt;
  logic              r_instr_valid;
  logic              w_instr_valid_nxt;
  logic              r_halted;
  logic              w_halted_nxt;

  logic              w_redirect;
  logic              w_accept;
  logic              w_capture;
  logic              w_is_halt;

  // Redirect only matters while fetching or draining and beats capture/accept.
  assign w_redirect = bus.redirect_valid && ((r_state == S_FETCH) || (r_state == S_DRAIN));
  assign w_accept   = r_instr_valid && bus.instr_ready;
  assign w_capture  = (r_state == S_FETCH) && (!r_instr_valid || bus.instr_ready) && !w_redirect;
  assign w_is_halt  = (bus.rom_data == HALT_WORD);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_redirect)                  w_state_nxt = S_FETCH;
        else if (w_capture && w_is_halt) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // The only word held in DRAIN is the halt word itself.
        if (w_redirect)    w_state_nxt = S_FETCH;
        else if (w_accept) w_state_nxt = S_HALTED;
      end
      S_HALTED: w_state_nxt = S_HALTED;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    w_pc_nxt          = r_pc;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;
    w_halted_nxt      = r_halted;
    if ((r_state == S_IDLE) && bus.start) begin
      w_pc_nxt = RESET_PC;
    end else if (w_redirect) begin
      w_pc_nxt          = bus.redirect_pc;
      w_instr_valid_nxt = 1'b0;
    end else if (w_capture) begin
      w_instr_nxt       = bus.rom_data;
      w_instr_pc_nxt    = r_pc;
      w_instr_valid_nxt = 1'b1;
      // The PC parks on the halt word's address.
      if (!w_is_halt) w_pc_nxt = r_pc + ADDR_W'(1);
    end else if (w_accept) begin
      w_instr_valid_nxt = 1'b0;
      if (r_state == S_DRAIN) w_halted_nxt = 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
      r_halted      <= w_halted_nxt;
    end
  end

  assign bus.rom_addr    = r_pc;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;
  assign bus.halted      = r_halted;

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_count;

  // Saturating count of words actually consumed by decode; flushed words excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= 16'd0;
    end else if (w_accept && !w_redirect && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  assign bus.fetch_count = r_fetch_count;
`else
  assign bus.fetch_count = 16'd0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Purpose : Self-checking bench for inst_fetch. Instance A (RESET_PC 0) covers
//           straight-line fetch, stalls, redirects, redirect during drain and
//           async reset; instance B (RESET_PC 1022) covers PC wrap.
module tb_inst_fetch;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 10;
  localparam logic [DW-1:0] HALT = 10'b0010000010;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] word;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  assign bus_a.rom_data = mem_a[bus_a.rom_addr];
  assign bus_b.rom_data = mem_b[bus_b.rom_addr];

  inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'd0), .HALT_WORD(HALT)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  inst_fetch #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(10'd1022), .HALT_WORD(HALT)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_a.start = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0; bus_a.instr_ready = 1'b0;
    bus_b.start = 1'b0; bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0; bus_b.instr_ready = 1'b0;
    q_a.delete();
    q_b.delete();
    tick(2);
    rst_n = 1'b1;
  endtask

  // Non-halt program with a halt word placed at halt_at.
  task automatic load_a(input int halt_at);
    for (int i = 0; i < 1024; i++) mem_a[i] = 10'(12'h100 + i);
    mem_a[10'(halt_at)] = HALT;
  endtask

  task automatic push_a(input int pc);
    exp_t x;
    x.pc   = 10'(pc);
    x.word = mem_a[10'(pc)];
    q_a.push_back(x);
  endtask

  task automatic pulse_start(input bit sel_b);
    if (sel_b) bus_b.start = 1'b1; else bus_a.start = 1'b1;
    tick(1);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_halt_a(input int budget);
    int k = 0;
    while (!bus_a.halted && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq("halt_reached", 32'(bus_a.halted), 32'd1);
  endtask

  // Scoreboard for instance A: every word decode takes must be the next expected one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus_a.instr_valid === 1'b1 && bus_a.instr_ready && !bus_a.redirect_valid) begin
      if (q_a.size() == 0) begin
        check_eq("sb_unexpected_pc", 32'(bus_a.instr_pc), 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        check_eq("sb_pc", 32'(bus_a.instr_pc), 32'(e.pc));
        check_eq("sb_word", 32'(bus_a.instr), 32'(e.word));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    for (int i = 0; i < 1024; i++) mem_b[i] = 10'h200 ^ 10'(i);
    load_a(1023);

    // Reset state
    do_reset();
    check_eq("rst_valid", 32'(bus_a.instr_valid), 32'd0);
    check_eq("rst_instr", 32'(bus_a.instr), 32'd0);
    check_eq("rst_instr_pc", 32'(bus_a.instr_pc), 32'd0);
    check_eq("rst_halted", 32'(bus_a.halted), 32'd0);
    check_eq("rst_count", 32'(bus_a.fetch_count), 32'd0);
    check_eq("rst_rom_addr", 32'(bus_a.rom_addr), 32'd0);
    check_eq("rst_rom_addr_b", 32'(bus_b.rom_addr), 32'd1022);

    // Straight line: 0..3 back to back, pc 3 holds the halt word
    load_a(3);
    mem_a[0] = 10'h370; mem_a[1] = 10'h36D; mem_a[2] = 10'h029;
    for (int i = 0; i < 4; i++) push_a(i);
    bus_a.instr_ready = 1'b1;
    pulse_start(1'b0);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("line_valid", 32'(bus_a.instr_valid), 32'd1);
      check_eq("line_pc", 32'(bus_a.instr_pc), 32'(i));
      check_eq("line_not_halted", 32'(bus_a.halted), 32'd0);
      tick(1);
    end
    @(negedge clk);
    check_eq("line_halted", 32'(bus_a.halted), 32'd1);
    check_eq("line_valid_off", 32'(bus_a.instr_valid), 32'd0);
    check_eq("line_rom_addr", 32'(bus_a.rom_addr), 32'd3);
    check_eq("line_count", 32'(bus_a.fetch_count), PERF ? 32'd4 : 32'd0);
    check_eq("line_sb_empty", 32'(q_a.size()), 32'd0);
    tick(3);
    check_eq("line_hold_addr", 32'(bus_a.rom_addr), 32'd3);
    check_eq("line_hold_halted", 32'(bus_a.halted), 32'd1);

    // Stall three cycles on pc 1
    do_reset();
    load_a(10);
    for (int i = 0; i <= 10; i++) push_a(i);
    bus_a.instr_ready = 1'b1;
    pulse_start(1'b0);
    tick(2);
    bus_a.instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", 32'(bus_a.instr_valid), 32'd1);
      check_eq("stall_pc", 32'(bus_a.instr_pc), 32'd1);
      check_eq("stall_instr", 32'(bus_a.instr), 32'(mem_a[1]));
      check_eq("stall_rom_addr", 32'(bus_a.rom_addr), 32'd2);
      tick(1);
    end
    bus_a.instr_ready = 1'b1;
    wait_halt_a(40);
    check_eq("stall_sb_empty", 32'(q_a.size()), 32'd0);
    check_eq("stall_count", 32'(bus_a.fetch_count), PERF ? 32'd11 : 32'd0);

    // Redirect to 9 while pc 5 is valid
    do_reset();
    load_a(16);
    for (int i = 0; i < 5; i++) push_a(i);
    for (int i = 9; i <= 16; i++) push_a(i);
    bus_a.instr_ready = 1'b1;
    pulse_start(1'b0);
    tick(6);
    check_eq("redir_pre_pc", 32'(bus_a.instr_pc), 32'd5);
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 10'd9;
    tick(1);
    bus_a.redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("redir_bubble", 32'(bus_a.instr_valid), 32'd0);
    check_eq("redir_rom_addr", 32'(bus_a.rom_addr), 32'd9);
    tick(1);
    @(negedge clk);
    check_eq("redir_valid", 32'(bus_a.instr_valid), 32'd1);
    check_eq("redir_pc", 32'(bus_a.instr_pc), 32'd9);
    wait_halt_a(40);
    check_eq("redir_sb_empty", 32'(q_a.size()), 32'd0);
    check_eq("redir_count", 32'(bus_a.fetch_count), PERF ? 32'd13 : 32'd0);

    // Redirect to 3 while the halt word at pc 8 is draining
    do_reset();
    load_a(8);
    for (int i = 0; i < 8; i++) push_a(i);
    for (int i = 3; i <= 8; i++) push_a(i);
    bus_a.instr_ready = 1'b1;
    pulse_start(1'b0);
    tick(9);
    check_eq("drain_pc", 32'(bus_a.instr_pc), 32'd8);
    check_eq("drain_word", 32'(bus_a.instr), 32'(HALT));
    bus_a.instr_ready    = 1'b0;
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc    = 10'd3;
    tick(1);
    bus_a.redirect_valid = 1'b0;
    bus_a.instr_ready    = 1'b1;
    @(negedge clk);
    check_eq("drain_not_halted", 32'(bus_a.halted), 32'd0);
    check_eq("drain_bubble", 32'(bus_a.instr_valid), 32'd0);
    tick(1);
    @(negedge clk);
    check_eq("drain_resume_pc", 32'(bus_a.instr_pc), 32'd3);
    check_eq("drain_resume_valid", 32'(bus_a.instr_valid), 32'd1);
    check_eq("drain_still_running", 32'(bus_a.halted), 32'd0);
    wait_halt_a(40);
    check_eq("drain_sb_empty", 32'(q_a.size()), 32'd0);
    check_eq("drain_count", 32'(bus_a.fetch_count), PERF ? 32'd14 : 32'd0);

    // Async reset during a stall
    do_reset();
    load_a(10);
    for (int i = 0; i <= 10; i++) push_a(i);
    bus_a.instr_ready = 1'b1;
    pulse_start(1'b0);
    tick(2);
    bus_a.instr_ready = 1'b0;
    @(negedge clk);
    check_eq("arst_pre_valid", 32'(bus_a.instr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus_a.instr_valid), 32'd0);
    check_eq("arst_instr", 32'(bus_a.instr), 32'd0);
    check_eq("arst_instr_pc", 32'(bus_a.instr_pc), 32'd0);
    check_eq("arst_halted", 32'(bus_a.halted), 32'd0);
    check_eq("arst_count", 32'(bus_a.fetch_count), 32'd0);
    check_eq("arst_rom_addr", 32'(bus_a.rom_addr), 32'd0);
    q_a.delete();
    tick(1);
    rst_n = 1'b1;
    bus_a.instr_ready = 1'b1;
    tick(4);
    @(negedge clk);
    check_eq("arst_idle_valid", 32'(bus_a.instr_valid), 32'd0);
    check_eq("arst_idle_addr", 32'(bus_a.rom_addr), 32'd0);
    for (int i = 0; i <= 10; i++) push_a(i);
    tick(1);
    pulse_start(1'b0);
    wait_halt_a(40);
    check_eq("arst_sb_empty", 32'(q_a.size()), 32'd0);
    check_eq("arst_final_count", 32'(bus_a.fetch_count), PERF ? 32'd11 : 32'd0);

    // PC wrap on instance B: 1022, 1023, 0, 1
    do_reset();
    check_eq("wrap_rst_addr", 32'(bus_b.rom_addr), 32'd1022);
    for (int i = 0; i < 4; i++) begin
      e.pc   = 10'(1022 + i);
      e.word = mem_b[e.pc];
      q_b.push_back(e);
    end
    bus_b.instr_ready = 1'b1;
    pulse_start(1'b1);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = q_b.pop_front();
      check_eq("wrap_valid", 32'(bus_b.instr_valid), 32'd1);
      check_eq("wrap_pc", 32'(bus_b.instr_pc), 32'(e.pc));
      check_eq("wrap_word", 32'(bus_b.instr), 32'(e.word));
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
